// File: rtl/usb_packetizer.sv
// Frames sign-extended samples into sync/sequence/payload byte frames for an
// FT245-style USB output stage, buffering samples in a small FIFO.
module usb_packetizer #(
  parameter int USB_DATA_WIDTH    = 8,
  parameter int SAMPLE_WIDTH      = 14,
  parameter int SAMPLES_PER_FRAME = 1024,
  parameter int FIFO_AW           = 4
) (
  input  logic                      clk_60mhz_i,
  input  logic                      rst_n_i,
  input  logic [SAMPLE_WIDTH-1:0]   sample_i,
  input  logic                      sample_valid_i,
  input  logic                      txe_n_i,
  output logic [USB_DATA_WIDTH-1:0] wdata_o,
  output logic                      send_data_o,
  output logic                      overflow_o,
  output logic [15:0]               frame_seq_o
);

  typedef enum logic [2:0] {
    IDLE, SYNC0, SYNC1, SEQ_HI, SEQ_LO, DAT_HI, DAT_LO
  } state_t;

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [15:0]      mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic             full, empty, avail_n, consumed, pop, wr_en;
  logic [15:0]      sample_ext, head, head_n;

  state_t        state, state_n;
  logic [15:0]   seq, seq_n, cnt, cnt_n;
  logic [7:0]    wdata_n;
  logic          send_n;

  assign sample_ext = 16'($signed(sample_i));
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign consumed   = send_data_o && !txe_n_i;
  assign pop        = consumed && (state == DAT_LO);
  // A pop on the same edge frees the slot, so a write while full still lands.
  assign wr_en      = sample_valid_i && (!full || pop);

  // Head after this edge's pop; a write on this same edge is not yet visible.
  assign rd_ptr_n   = rd_ptr + {{FIFO_AW{1'b0}}, pop};
  assign avail_n    = (wr_ptr != rd_ptr_n);
  assign head       = mem[rd_ptr[FIFO_AW-1:0]];
  assign head_n     = mem[rd_ptr_n[FIFO_AW-1:0]];

  // NOTE: storage array carries no reset; the pointers alone define its contents.
  always_ff @(posedge clk_60mhz_i) begin
    if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= sample_ext;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_n = state;
    seq_n   = seq;
    cnt_n   = cnt;
    case (state)
      IDLE:   if (!empty) state_n = SYNC0;
      SYNC0:  if (consumed) state_n = SYNC1;
      SYNC1:  if (consumed) state_n = SEQ_HI;
      SEQ_HI: if (consumed) state_n = SEQ_LO;
      SEQ_LO: if (consumed) state_n = DAT_HI;
      DAT_HI: if (consumed) state_n = DAT_LO;
      DAT_LO: begin
        if (consumed) begin
          if (({1'b0, cnt} + 17'd1) < 17'(SAMPLES_PER_FRAME)) begin
            state_n = DAT_HI;
            cnt_n   = cnt + 16'd1;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
            seq_n   = seq + 16'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Output registers are loaded from the state being entered.
    send_n  = 1'b1;
    wdata_n = wdata_o;
    case (state_n)
      SYNC0:  wdata_n = 8'hA5;
      SYNC1:  wdata_n = 8'h5A;
      SEQ_HI: wdata_n = seq_n[15:8];
      SEQ_LO: wdata_n = seq_n[7:0];
      DAT_HI: begin
        send_n = avail_n;
        if (avail_n) wdata_n = head_n[15:8];
      end
      DAT_LO: wdata_n = head[7:0];
      default: send_n = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_60mhz_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      seq         <= '0;
      cnt         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wdata_o     <= '0;
      send_data_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      state       <= state_n;
      seq         <= seq_n;
      cnt         <= cnt_n;
      rd_ptr      <= rd_ptr_n;
      wdata_o     <= wdata_n;
      send_data_o <= send_n;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (sample_valid_i && !wr_en) overflow_o <= 1'b1;
    end
  end

  assign frame_seq_o = seq;

endmodule

// File: tb/tb_usb_packetizer.sv
// Directed bench for usb_packetizer: framing, stalls, overflow, starvation, reset.
module tb_usb_packetizer;

  logic        clk_60mhz_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [13:0] sample_i = '0;
  logic        sample_valid_i = 1'b0;
  logic        txe_n_i = 1'b0;
  logic [7:0]  wdata_o;
  logic        send_data_o;
  logic        overflow_o;
  logic [15:0] frame_seq_o;

  int n_checks = 0;
  int n_fails  = 0;

  usb_packetizer #(
    .USB_DATA_WIDTH(8), .SAMPLE_WIDTH(14), .SAMPLES_PER_FRAME(2), .FIFO_AW(2)
  ) dut (
    .clk_60mhz_i(clk_60mhz_i), .rst_n_i(rst_n_i), .sample_i(sample_i),
    .sample_valid_i(sample_valid_i), .txe_n_i(txe_n_i), .wdata_o(wdata_o),
    .send_data_o(send_data_o), .overflow_o(overflow_o), .frame_seq_o(frame_seq_o)
  );

  always #5 clk_60mhz_i = ~clk_60mhz_i;

  task automatic tick();
    @(posedge clk_60mhz_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [13:0] s);
    sample_i = s;
    sample_valid_i = 1'b1;
    tick();
    sample_valid_i = 1'b0;
  endtask

  task automatic push2(input logic [13:0] s0, input logic [13:0] s1);
    push(s0);
    push(s1);
  endtask

  // Waits up to budget cycles for a byte, checks it, then lets it be consumed.
  task automatic expect_byte(input logic [7:0] exp, input string tag, input int budget);
    int w = 0;
    while (!send_data_o && w < budget) begin
      tick();
      w++;
    end
    check({tag, "_send"}, {15'd0, send_data_o}, 16'h0001);
    check(tag, {8'h00, wdata_o}, {8'h00, exp});
    tick();
  endtask

  task automatic expect_frame(input logic [15:0] seq, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input string tag);
    expect_byte(8'hA5,     {tag, "_sync0"}, 20);
    expect_byte(8'h5A,     {tag, "_sync1"}, 0);
    expect_byte(seq[15:8], {tag, "_seqhi"}, 0);
    expect_byte(seq[7:0],  {tag, "_seqlo"}, 0);
    expect_byte(b0,        {tag, "_d0hi"},  0);
    expect_byte(b1,        {tag, "_d0lo"},  0);
    expect_byte(b2,        {tag, "_d1hi"},  0);
    expect_byte(b3,        {tag, "_d1lo"},  0);
    check({tag, "_idle"}, {15'd0, send_data_o}, 16'h0000);
    check({tag, "_seq_out"}, frame_seq_o, seq + 16'd1);
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    check("rst_wdata", {8'h00, wdata_o}, 16'h0000);
    check("rst_send", {15'd0, send_data_o}, 16'h0000);
    check("rst_ovf", {15'd0, overflow_o}, 16'h0000);
    check("rst_seq", frame_seq_o, 16'h0000);
    rst_n_i = 1'b1;
    tick();

    // Basic frame with positive and negative extremes
    push2(14'h1FFF, 14'h2000);
    check("t1_first_a5_latency", {7'd0, send_data_o, wdata_o}, 16'h01A5);
    expect_frame(16'h0000, 8'h1F, 8'hFF, 8'hE0, 8'h00, "t1");
    tick();
    check("t1_stay_idle", {15'd0, send_data_o}, 16'h0000);

    // Three streamed frames after a fresh reset
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    tick();
    push2(14'h0001, 14'h3FFF);
    expect_frame(16'h0000, 8'h00, 8'h01, 8'hFF, 8'hFF, "t2f0");
    push2(14'h1234, 14'h2345);
    expect_frame(16'h0001, 8'h12, 8'h34, 8'hE3, 8'h45, "t2f1");
    push2(14'h0ABC, 14'h3000);
    expect_frame(16'h0002, 8'h0A, 8'hBC, 8'hF0, 8'h00, "t2f2");

    // Stall for 5 cycles while SEQ_LO is presented
    push2(14'h0123, 14'h3F00);
    expect_byte(8'hA5, "t3_sync0", 20);
    expect_byte(8'h5A, "t3_sync1", 0);
    expect_byte(8'h00, "t3_seqhi", 0);
    txe_n_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold", {7'd0, send_data_o, wdata_o}, 16'h0103);
    end
    txe_n_i = 1'b0;
    expect_byte(8'h03, "t3_seqlo", 0);
    expect_byte(8'h01, "t3_d0hi", 0);
    expect_byte(8'h23, "t3_d0lo", 0);
    expect_byte(8'hFF, "t3_d1hi", 0);
    expect_byte(8'h00, "t3_d1lo", 0);
    check("t3_idle", {15'd0, send_data_o}, 16'h0000);

    // Overflow: five samples into a four-entry FIFO while the host is busy
    txe_n_i = 1'b1;
    push(14'h0011);
    push(14'h0022);
    push(14'h0033);
    push(14'h0044);
    check("t4_no_ovf_yet", {15'd0, overflow_o}, 16'h0000);
    push(14'h0055);
    check("t4_ovf_set", {15'd0, overflow_o}, 16'h0001);
    tick();
    tick();
    check("t4_ovf_sticky", {15'd0, overflow_o}, 16'h0001);
    check("t4_held_a5", {7'd0, send_data_o, wdata_o}, 16'h01A5);
    txe_n_i = 1'b0;
    expect_frame(16'h0004, 8'h00, 8'h11, 8'h00, 8'h22, "t4f0");
    expect_frame(16'h0005, 8'h00, 8'h33, 8'h00, 8'h44, "t4f1");
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_fifo_drained", {15'd0, send_data_o}, 16'h0000);
    end

    // Samples spaced 10 cycles apart: DAT_HI starves, order preserved
    push(14'h0100);
    expect_byte(8'hA5, "t5_sync0", 5);
    expect_byte(8'h5A, "t5_sync1", 0);
    expect_byte(8'h00, "t5_seqhi", 0);
    expect_byte(8'h06, "t5_seqlo", 0);
    expect_byte(8'h01, "t5_d0hi", 0);
    expect_byte(8'h00, "t5_d0lo", 0);
    check("t5_starve", {15'd0, send_data_o}, 16'h0000);
    tick();
    check("t5_starve2", {15'd0, send_data_o}, 16'h0000);
    check("t5_ovf_still", {15'd0, overflow_o}, 16'h0001);
    tick();
    push(14'h3FFE);
    expect_byte(8'hFF, "t5_d1hi", 5);
    expect_byte(8'hFE, "t5_d1lo", 0);
    check("t5_idle", {15'd0, send_data_o}, 16'h0000);
    check("t5_seq_out", frame_seq_o, 16'h0007);

    // Reset in the middle of DAT_LO
    push2(14'h0005, 14'h0006);
    expect_byte(8'hA5, "t6_sync0", 20);
    expect_byte(8'h5A, "t6_sync1", 0);
    expect_byte(8'h00, "t6_seqhi", 0);
    expect_byte(8'h07, "t6_seqlo", 0);
    expect_byte(8'h00, "t6_d0hi", 0);
    check("t6_in_datlo", {7'd0, send_data_o, wdata_o}, 16'h0105);
    rst_n_i = 1'b0;
    tick();
    check("t6_rst_wdata", {8'h00, wdata_o}, 16'h0000);
    check("t6_rst_send", {15'd0, send_data_o}, 16'h0000);
    check("t6_rst_ovf", {15'd0, overflow_o}, 16'h0000);
    check("t6_rst_seq", frame_seq_o, 16'h0000);
    rst_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_fifo_flushed", {15'd0, send_data_o}, 16'h0000);
    end
    push2(14'h0007, 14'h0008);
    expect_frame(16'h0000, 8'h00, 8'h07, 8'h00, 8'h08, "t6f");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
